// File: rtl/dbus_router.sv
// Data-bus router: decodes core loads/stores to MEM, UART or BAD and returns
// load responses in issue order through an in-order tag FIFO.
module dbus_router #(
  parameter int                XLEN      = 64,
  parameter int                DEPTH     = 4,
  parameter logic [XLEN-1:0]   MEM_BASE  = 64'h8000_0000,
  parameter logic [XLEN-1:0]   MEM_END   = 64'h8010_0000,
  parameter logic [XLEN-1:0]   UART_BASE = 64'h1000_0000,
  parameter logic [XLEN-1:0]   UART_END  = 64'h1000_0008,
  parameter logic [XLEN-1:0]   BAD_DATA  = 64'hbadabadabadabada
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_a_valid,
  output logic                       load_a_ready,
  input  logic [XLEN-1:0]            load_a_addr,
  output logic                       load_d_valid,
  output logic [XLEN-1:0]            load_d_data,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [XLEN-1:0]            waddr,
  input  logic [XLEN-1:0]            wdata,
  input  logic [7:0]                 wmask,
  output logic                       mem_ar_valid,
  input  logic                       mem_ar_ready,
  output logic [XLEN-1:0]            mem_ar_addr,
  input  logic                       mem_r_valid,
  output logic                       mem_r_ready,
  input  logic [XLEN-1:0]            mem_r_data,
  output logic                       uart_ar_valid,
  input  logic                       uart_ar_ready,
  output logic [XLEN-1:0]            uart_ar_addr,
  input  logic                       uart_r_valid,
  output logic                       uart_r_ready,
  input  logic [XLEN-1:0]            uart_r_data,
  output logic                       mem_wvalid,
  input  logic                       mem_wready,
  output logic                       uart_wvalid,
  input  logic                       uart_wready,
  output logic [XLEN-1:0]            dev_waddr,
  output logic [XLEN-1:0]            dev_wdata,
  output logic [7:0]                 dev_wmask,
  output logic                       load_err_o,
  output logic                       store_err_o,
  output logic [$clog2(DEPTH):0]     outstanding_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    TGT_MEM  = 2'd0,
    TGT_UART = 2'd1,
    TGT_BAD  = 2'd2
  } tgt_t;

  // MEM wins if the two windows are ever configured to overlap.
  function automatic tgt_t decode(input logic [XLEN-1:0] a);
    if (a >= MEM_BASE && a < MEM_END)
      return TGT_MEM;
    else if (a >= UART_BASE && a < UART_END)
      return TGT_UART;
    else
      return TGT_BAD;
  endfunction

  tgt_t            tags [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  tgt_t            ld_tgt;
  tgt_t            st_tgt;
  tgt_t            head;
  logic            full;
  logic            empty;
  logic            tgt_rdy;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] rsp_data;

  assign ld_tgt = decode(load_a_addr);
  assign st_tgt = decode(waddr);
  assign head   = tags[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  always_comb begin
    tgt_rdy = 1'b1;
    case (ld_tgt)
      TGT_MEM:  tgt_rdy = mem_ar_ready;
      TGT_UART: tgt_rdy = uart_ar_ready;
      default:  tgt_rdy = 1'b1;
    endcase
  end

  assign load_a_ready  = !full && tgt_rdy;
  assign push          = load_a_valid && load_a_ready;
  assign mem_ar_valid  = load_a_valid && (ld_tgt == TGT_MEM) && !full;
  assign uart_ar_valid = load_a_valid && (ld_tgt == TGT_UART) && !full;
  assign mem_ar_addr   = load_a_addr;
  assign uart_ar_addr  = load_a_addr;

  assign mem_r_ready   = !empty && (head == TGT_MEM);
  assign uart_r_ready  = !empty && (head == TGT_UART);

  // A BAD head completes on its own; device heads wait for their response.
  always_comb begin
    pop      = 1'b0;
    rsp_data = BAD_DATA;
    if (!empty) begin
      case (head)
        TGT_MEM: begin
          pop      = mem_r_valid;
          rsp_data = mem_r_data;
        end
        TGT_UART: begin
          pop      = uart_r_valid;
          rsp_data = uart_r_data;
        end
        default: begin
          pop      = 1'b1;
          rsp_data = BAD_DATA;
        end
      endcase
    end
  end

  assign mem_wvalid  = wvalid && (st_tgt == TGT_MEM);
  assign uart_wvalid = wvalid && (st_tgt == TGT_UART);
  assign wready      = (st_tgt == TGT_MEM)  ? mem_wready :
                       (st_tgt == TGT_UART) ? uart_wready : 1'b1;
  assign dev_waddr   = waddr;
  assign dev_wdata   = wdata;
  assign dev_wmask   = wmask;

  always_ff @(posedge clk) begin
    if (push)
      tags[wr_ptr] <= ld_tgt;
  end

  // Response stage: one registered cycle between pop and the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      load_d_valid <= 1'b0;
      load_d_data  <= '0;
      load_err_o   <= 1'b0;
      store_err_o  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      load_d_valid <= pop;
      if (pop)
        load_d_data <= rsp_data;
      load_err_o   <= pop && (head == TGT_BAD);
      store_err_o  <= wvalid && (st_tgt == TGT_BAD);
    end
  end

  assign outstanding_o = count;

endmodule

// File: tb/tb_dbus_router.sv
// Directed bench for dbus_router: decode, in-order completion, back-pressure,
// reset while loads are in flight, and store routing.
module tb_dbus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_a_valid;
  logic        load_a_ready;
  logic [63:0] load_a_addr;
  logic        load_d_valid;
  logic [63:0] load_d_data;
  logic        wvalid;
  logic        wready;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        mem_ar_valid;
  logic        mem_ar_ready;
  logic [63:0] mem_ar_addr;
  logic        mem_r_valid;
  logic        mem_r_ready;
  logic [63:0] mem_r_data;
  logic        uart_ar_valid;
  logic        uart_ar_ready;
  logic [63:0] uart_ar_addr;
  logic        uart_r_valid;
  logic        uart_r_ready;
  logic [63:0] uart_r_data;
  logic        mem_wvalid;
  logic        mem_wready;
  logic        uart_wvalid;
  logic        uart_wready;
  logic [63:0] dev_waddr;
  logic [63:0] dev_wdata;
  logic [7:0]  dev_wmask;
  logic        load_err_o;
  logic        store_err_o;
  logic [2:0]  outstanding_o;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dbus_router dut (
    .clk(clk), .rst(rst),
    .load_a_valid(load_a_valid), .load_a_ready(load_a_ready), .load_a_addr(load_a_addr),
    .load_d_valid(load_d_valid), .load_d_data(load_d_data),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
    .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
    .uart_ar_valid(uart_ar_valid), .uart_ar_ready(uart_ar_ready), .uart_ar_addr(uart_ar_addr),
    .uart_r_valid(uart_r_valid), .uart_r_ready(uart_r_ready), .uart_r_data(uart_r_data),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .uart_wvalid(uart_wvalid), .uart_wready(uart_wready),
    .dev_waddr(dev_waddr), .dev_wdata(dev_wdata), .dev_wmask(dev_wmask),
    .load_err_o(load_err_o), .store_err_o(store_err_o), .outstanding_o(outstanding_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_a_valid = 0; load_a_addr = '0;
    wvalid = 0; waddr = '0; wdata = '0; wmask = '0;
    mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = '0;
    uart_ar_ready = 0; uart_r_valid = 0; uart_r_data = '0;
    mem_wready = 0; uart_wready = 0;
    #2;
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_d_valid", 64'(load_d_valid), 64'd0);
    chk("rst_d_data", load_d_data, 64'd0);
    chk("rst_load_err", 64'(load_err_o), 64'd0);
    chk("rst_store_err", 64'(store_err_o), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // MEM load with 1-cycle device response
    mem_ar_ready = 1; uart_ar_ready = 1;
    load_a_valid = 1; load_a_addr = 64'h8000_0010;
    #1;
    chk("t1_a_ready", 64'(load_a_ready), 64'd1);
    chk("t1_mem_ar_valid", 64'(mem_ar_valid), 64'd1);
    chk("t1_uart_ar_valid", 64'(uart_ar_valid), 64'd0);
    chk("t1_mem_ar_addr", mem_ar_addr, 64'h8000_0010);
    tick();
    load_a_valid = 0;
    chk("t1_outstanding1", 64'(outstanding_o), 64'd1);
    mem_r_valid = 1; mem_r_data = 64'h1122334455667788;
    #1;
    chk("t1_mem_r_ready", 64'(mem_r_ready), 64'd1);
    chk("t1_d_valid_early", 64'(load_d_valid), 64'd0);
    tick();
    mem_r_valid = 0; mem_r_data = '0;
    chk("t1_d_valid", 64'(load_d_valid), 64'd1);
    chk("t1_d_data", load_d_data, 64'h1122334455667788);
    chk("t1_outstanding0", 64'(outstanding_o), 64'd0);
    chk("t1_no_err", 64'(load_err_o), 64'd0);
    tick();
    chk("t1_d_valid_drop", 64'(load_d_valid), 64'd0);
    chk("t1_d_data_hold", load_d_data, 64'h1122334455667788);

    // UART load then MEM load; MEM responds early but must wait
    load_a_valid = 1; load_a_addr = 64'h1000_0005;
    #1;
    chk("t2_uart_ar_valid", 64'(uart_ar_valid), 64'd1);
    chk("t2_uart_ar_addr", uart_ar_addr, 64'h1000_0005);
    chk("t2_mem_ar_valid0", 64'(mem_ar_valid), 64'd0);
    tick();
    load_a_addr = 64'h8000_0020;
    tick();
    load_a_valid = 0;
    chk("t2_outstanding2", 64'(outstanding_o), 64'd2);
    mem_r_valid = 1; mem_r_data = 64'h0000_0000_cafe_f00d;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_mem_r_stall", 64'(mem_r_ready), 64'd0);
      chk("t2_no_resp", 64'(load_d_valid), 64'd0);
      tick();
    end
    uart_r_valid = 1; uart_r_data = 64'h0000_0000_0000_0041;
    #1;
    chk("t2_uart_r_ready", 64'(uart_r_ready), 64'd1);
    tick();
    uart_r_valid = 0;
    #1;
    chk("t2_first_valid", 64'(load_d_valid), 64'd1);
    chk("t2_first_data", load_d_data, 64'h41);
    chk("t2_mem_r_ready", 64'(mem_r_ready), 64'd1);
    tick();
    mem_r_valid = 0;
    chk("t2_second_valid", 64'(load_d_valid), 64'd1);
    chk("t2_second_data", load_d_data, 64'h0000_0000_cafe_f00d);
    chk("t2_outstanding0", 64'(outstanding_o), 64'd0);
    tick();

    // BAD load, then BAD store
    load_a_valid = 1; load_a_addr = 64'h0000_0040;
    #1;
    chk("t3_a_ready", 64'(load_a_ready), 64'd1);
    chk("t3_no_ar", 64'({mem_ar_valid, uart_ar_valid}), 64'd0);
    tick();
    load_a_valid = 0;
    chk("t3_outstanding1", 64'(outstanding_o), 64'd1);
    chk("t3_not_yet", 64'(load_d_valid), 64'd0);
    tick();
    chk("t3_d_valid", 64'(load_d_valid), 64'd1);
    chk("t3_d_data", load_d_data, 64'hbadabadabadabada);
    chk("t3_load_err", 64'(load_err_o), 64'd1);
    chk("t3_outstanding0", 64'(outstanding_o), 64'd0);
    tick();
    chk("t3_load_err_drop", 64'(load_err_o), 64'd0);
    wvalid = 1; waddr = 64'h0; wdata = 64'h55; wmask = 8'hff;
    #1;
    chk("t3_wready", 64'(wready), 64'd1);
    chk("t3_no_dev_wvalid", 64'({mem_wvalid, uart_wvalid}), 64'd0);
    tick();
    wvalid = 0;
    chk("t3_store_err", 64'(store_err_o), 64'd1);
    tick();
    chk("t3_store_err_drop", 64'(store_err_o), 64'd0);

    // Fill the FIFO with MEM loads that never answer
    load_a_valid = 1; load_a_addr = 64'h8000_0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_accept", 64'(load_a_ready), 64'd1);
      tick();
    end
    chk("t4_outstanding4", 64'(outstanding_o), 64'd4);
    chk("t4_full_ready", 64'(load_a_ready), 64'd0);
    chk("t4_full_ar_valid", 64'(mem_ar_valid), 64'd0);
    mem_r_valid = 1; mem_r_data = 64'h77;
    #1;
    chk("t4_pop_no_free", 64'(load_a_ready), 64'd0);
    tick();
    mem_r_valid = 0;
    chk("t4_outstanding3", 64'(outstanding_o), 64'd3);
    chk("t4_ready_after_pop", 64'(load_a_ready), 64'd1);
    tick();
    load_a_valid = 0;
    chk("t4_refill", 64'(outstanding_o), 64'd4);
    mem_r_valid = 1; mem_r_data = 64'h78;
    tick();
    mem_r_valid = 0;
    chk("t4_outstanding3b", 64'(outstanding_o), 64'd3);
    chk("t4_d_valid", 64'(load_d_valid), 64'd1);

    // Asynchronous reset with three loads in flight
    rst = 1;
    #1;
    chk("t5_outstanding0", 64'(outstanding_o), 64'd0);
    chk("t5_d_valid0", 64'(load_d_valid), 64'd0);
    chk("t5_d_data0", load_d_data, 64'd0);
    tick();
    rst = 0;
    mem_r_valid = 1; mem_r_data = 64'h99;
    #1;
    chk("t5_empty_r_ready", 64'(mem_r_ready), 64'd0);
    tick();
    mem_r_valid = 0;
    chk("t5_stale_ignored", 64'(load_d_valid), 64'd0);
    load_a_valid = 1; load_a_addr = 64'h800F_FFF8;
    tick();
    load_a_valid = 0;
    mem_r_valid = 1; mem_r_data = 64'hdead_beef_0000_0001;
    tick();
    mem_r_valid = 0;
    chk("t5_post_valid", 64'(load_d_valid), 64'd1);
    chk("t5_post_data", load_d_data, 64'hdead_beef_0000_0001);
    chk("t5_post_outstanding", 64'(outstanding_o), 64'd0);

    // UART store back-pressured while a MEM load proceeds
    uart_wready = 0; mem_wready = 1;
    wvalid = 1; waddr = 64'h1000_0007; wdata = 64'h0123_4567_89ab_cdef; wmask = 8'h80;
    load_a_valid = 1; load_a_addr = 64'h8000_0008;
    #1;
    chk("t6_wready_c1", 64'(wready), 64'd0);
    chk("t6_uart_wvalid", 64'(uart_wvalid), 64'd1);
    chk("t6_mem_wvalid", 64'(mem_wvalid), 64'd0);
    chk("t6_dev_waddr", dev_waddr, 64'h1000_0007);
    chk("t6_dev_wdata", dev_wdata, 64'h0123_4567_89ab_cdef);
    chk("t6_dev_wmask", 64'(dev_wmask), 64'h80);
    chk("t6_load_ready", 64'(load_a_ready), 64'd1);
    tick();
    load_a_valid = 0;
    mem_r_valid = 1; mem_r_data = 64'h6666;
    #1;
    chk("t6_wready_c2", 64'(wready), 64'd0);
    tick();
    mem_r_valid = 0;
    uart_wready = 1;
    #1;
    chk("t6_wready_c3", 64'(wready), 64'd1);
    chk("t6_load_valid", 64'(load_d_valid), 64'd1);
    chk("t6_load_data", load_d_data, 64'h6666);
    tick();
    wvalid = 0;
    chk("t6_no_store_err", 64'(store_err_o), 64'd0);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/dbus_router.md
Name: dbus_router

Overview:
- Data-bus router sitting directly downstream of the core's dcache_ports_if.
- Decodes each load/store address into one of three targets: MEM (sram data port), UART (uart8250) or BAD.
- Forwards each request to its target with valid/ready handshakes.
- Tracks up to DEPTH outstanding loads in an in-order tag FIFO so that responses from devices of differing latency return to the core in issue order.
- Replaces the fixed 1-cycle fake read path and address splitter at system level.

Parameters:
- XLEN, 64, data/address width.
- DEPTH, 4, max outstanding loads (power of two, >=2).
- MEM_BASE, 64'h8000_0000, first MEM byte address.
- MEM_END, 64'h8010_0000, MEM end (exclusive).
- UART_BASE, 64'h1000_0000, first UART byte address.
- UART_END, 64'h1000_0008, UART end (exclusive).
- BAD_DATA, 64'hbadabadabadabada, load data returned for unmapped addresses.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_a_valid  in  1  core load request
- load_a_ready  out  1  load request accepted
- load_a_addr  in  XLEN  load byte address
- load_d_valid  out  1  load response to core (core always accepts)
- load_d_data  out  XLEN  load response data
- wvalid  in  1  core store request
- wready  out  1  store accepted
- waddr  in  XLEN  store byte address
- wdata  in  XLEN  store data
- wmask  in  8  store byte mask
- mem_ar_valid / mem_ar_ready  out/in  1  MEM read request handshake
- mem_ar_addr  out  XLEN  MEM read address (= load_a_addr)
- mem_r_valid / mem_r_ready  in/out  1  MEM read response handshake
- mem_r_data  in  XLEN  MEM read data
- uart_ar_valid / uart_ar_ready / uart_ar_addr / uart_r_valid / uart_r_ready / uart_r_data: same meaning for UART
- mem_wvalid, mem_wready  out/in  1  MEM store handshake
- uart_wvalid, uart_wready  out/in  1  UART store handshake
- dev_waddr, dev_wdata, dev_wmask  out  XLEN/XLEN/8  store payload shared by both devices
- load_err_o  out  1  1-cycle pulse with a BAD load response
- store_err_o  out  1  1-cycle pulse when a BAD store is accepted
- outstanding_o  out  clog2(DEPTH)+1  current tag FIFO occupancy

Behaviour:
- Reset: asynchronous on rst. Tag FIFO emptied. load_d_valid=0, load_d_data=0, load_err_o=0, store_err_o=0, outstanding_o=0. Tags in flight are discarded.
- Devices share rst. Any response presented after rst deasserts is never accepted, because r_ready=0 while the FIFO is empty.
- Decode: hit = BASE <= addr < END, full XLEN unsigned compare. MEM takes priority if ranges overlap. No hit means BAD.
- Load accept: fire = load_a_valid && load_a_ready. load_a_ready = !full && (target ready, or target==BAD).
  - Full is evaluated on current occupancy only. A pop in the same cycle does not free a slot.
  - X_ar_valid = load_a_valid && target==X && !full, combinational from inputs.
  - On fire, the target tag (MEM/UART/BAD) is pushed.
- Response: only the FIFO head may complete.
  - mem_r_ready = !empty && head==MEM; uart_r_ready likewise.
  - Head MEM or UART: pops when X_r_valid && X_r_ready.
  - Head BAD: pops unconditionally in the cycle it is head.
  - On pop, registered next cycle: load_d_valid=1; load_d_data = device data, or BAD_DATA for a BAD head; load_err_o=1 only for BAD.
  - Otherwise load_d_valid=0 and load_d_data holds its last value.
  - Latency: device response at cycle N gives load_d_valid at N+1. A BAD load accepted into an empty FIFO at cycle N gives load_d_valid at N+2.
- Push and pop in the same cycle: both occur; occupancy unchanged. Pointers wrap modulo DEPTH.
- Out-of-order device readiness: a ready response from a non-head device stalls (r_ready=0) until that device's tag reaches the head.
- Stores:
  - X_wvalid = wvalid && target==X.
  - wready = the target device's wready, or 1 for BAD.
  - BAD store: accepted and dropped; store_err_o pulses in the following cycle.
  - dev_* mirror waddr/wdata/wmask combinationally.
  - No load/store ordering is enforced beyond per-device order.
- A store and a load may fire in the same cycle, to the same or different devices.
- outstanding_o is the registered occupancy.

Test Plan:
- MEM load with mem_ar_ready=1 and 1-cycle device response, addr 0x8000_0010, data 0x1122334455667788 -> load_d_valid at cycle+2 with that data; outstanding 1→0.
- Issue UART load 0x1000_0005 (response after 5 cycles), then MEM load (response after 1 cycle) -> mem_r_ready held 0 until UART pops; core sees UART data then MEM data, in order.
- Load 0x0000_0040 (BAD) -> load_d_data=0xbadabadabadabada and load_err_o=1 for one cycle. Store to 0x0 -> wready=1, store_err_o pulses, no device wvalid.
- Devices never respond; issue 5 MEM loads with DEPTH=4 -> 4 accepted, load_a_ready=0 on the 5th, outstanding_o=4. Release one response -> the 5th is accepted the cycle after the pop.
- Assert rst with 3 loads outstanding -> outputs 0 and outstanding_o=0 at once; a post-reset load completes normally.
- Store to UART with uart_wready=0 for 2 cycles -> wready=0 for 2 cycles, accepted on the 3rd; a MEM load in the same cycles proceeds unaffected.
